gs_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one SRAM_wrapper macro (16K x 32, byte-writable) between the core's instruction-fetch port and its load/store port. It sits between the core and a single SRAM in GS_Top. It issues at most one SRAM access per cycle and routes each response back to its owner with a one-entry hold buffer per port. Arbitration is data-first with a bounded starvation guard for instruction fetch.

---
 rtl/gs_mem_arbiter_if.sv | 53 +++++
 rtl/gs_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_gs_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_mem_arbiter_if.sv
// gs_mem_arbiter_if: requester handshakes and SRAM macro pins shared by the arbiter and its environment.
interface gs_mem_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BYTES     = 4,
  parameter int unsigned SRAM_AW   = 14
);
  // Instruction-fetch port
  logic                 if_req_valid;
  logic [ADDR_SIZE-1:0] if_req_addr;
  logic                 if_req_ready;
  logic                 if_rsp_valid;
  logic [WORD_SIZE-1:0] if_rsp_rdata;
  logic                 if_rsp_ready;

  // Load/store port
  logic                 dm_req_valid;
  logic [BYTES-1:0]     dm_req_we;
  logic [ADDR_SIZE-1:0] dm_req_addr;
  logic [WORD_SIZE-1:0] dm_req_wdata;
  logic                 dm_req_ready;
  logic                 dm_rsp_valid;
  logic [WORD_SIZE-1:0] dm_rsp_rdata;
  logic                 dm_rsp_ready;

  // SRAM macro
  logic                 sram_cs;
  logic                 sram_oe;
  logic [BYTES-1:0]     sram_web;
  logic [SRAM_AW-1:0]   sram_a;
  logic [WORD_SIZE-1:0] sram_di;
  logic [WORD_SIZE-1:0] sram_do;

  // Arbiter view
  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_rsp_ready,
    output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    output sram_cs, sram_oe, sram_web, sram_a, sram_di,
    input  sram_do
  );

  // Core + SRAM environment view
  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_rsp_ready,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    input  sram_cs, sram_oe, sram_web, sram_a, sram_di,
    output sram_do
  );
endinterface

// File: rtl/gs_mem_arbiter.sv
// gs_mem_arbiter: shares one byte-writable SRAM between instruction fetch and load/store.
// Data-first arbitration with a bounded streak guard so fetch cannot starve; one
// in-flight access plus a one-entry response hold buffer per port.
module gs_mem_arbiter #(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned BYTES           = 4,
  parameter int unsigned SRAM_AW         = 14,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  gs_mem_arbiter_if.slave   bus
);
  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic                 inflight_if_q, inflight_if_d;
  logic                 inflight_dm_q, inflight_dm_d;
  logic                 inflight_wr_q, inflight_wr_d;
  logic                 hold_if_valid_q, hold_if_valid_d;
  logic                 hold_dm_valid_q, hold_dm_valid_d;
  logic [WORD_SIZE-1:0] hold_if_data_q, hold_if_data_d;
  logic [WORD_SIZE-1:0] hold_dm_data_q, hold_dm_data_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;

  logic                 elig_if_c, elig_dm_c;
  logic                 grant_if_c, grant_dm_c;
  logic [WORD_SIZE-1:0] if_rsp_data_c, dm_rsp_data_c;
  logic                 unused_addr_bits;

  // Only word-address bits reach the SRAM; byte offset and high bits are ignored.
  assign unused_addr_bits = ^{bus.if_req_addr[1:0], bus.if_req_addr[ADDR_SIZE-1:SRAM_AW+2],
                              bus.dm_req_addr[1:0], bus.dm_req_addr[ADDR_SIZE-1:SRAM_AW+2]};

  // Eligibility and single-grant arbitration; fetch wins once data has had its full streak.
  always_comb begin
    elig_if_c  = !hold_if_valid_q && !(inflight_if_q && !bus.if_rsp_ready);
    elig_dm_c  = !hold_dm_valid_q && !(inflight_dm_q && !bus.dm_rsp_ready);
    grant_if_c = 1'b0;
    grant_dm_c = 1'b0;
    if (!rst) begin
      if (bus.if_req_valid && elig_if_c &&
          (!(bus.dm_req_valid && elig_dm_c) || (streak_q == STREAK_MAX))) begin
        grant_if_c = 1'b1;
      end else if (bus.dm_req_valid && elig_dm_c) begin
        grant_dm_c = 1'b1;
      end
    end
  end

  // SRAM command for the granted requester; idle bus parks at zero with writes disabled.
  always_comb begin
    bus.sram_cs  = grant_if_c | grant_dm_c;
    bus.sram_web = {BYTES{1'b1}};
    bus.sram_a   = '0;
    bus.sram_di  = '0;
    if (grant_dm_c) begin
      bus.sram_a   = bus.dm_req_addr[SRAM_AW+1:2];
      bus.sram_web = ~bus.dm_req_we;
      bus.sram_di  = bus.dm_req_wdata;
    end else if (grant_if_c) begin
      bus.sram_a   = bus.if_req_addr[SRAM_AW+1:2];
    end
    bus.sram_oe  = inflight_if_q | (inflight_dm_q & !inflight_wr_q);
  end

  // Response muxing: held data has priority, otherwise the live SRAM result.
  always_comb begin
    if_rsp_data_c = '0;
    dm_rsp_data_c = '0;
    if (hold_if_valid_q)    if_rsp_data_c = hold_if_data_q;
    else if (inflight_if_q) if_rsp_data_c = bus.sram_do;
    if (hold_dm_valid_q)    dm_rsp_data_c = hold_dm_data_q;
    else if (inflight_dm_q) dm_rsp_data_c = inflight_wr_q ? '0 : bus.sram_do;
    bus.if_req_ready = grant_if_c;
    bus.dm_req_ready = grant_dm_c;
    bus.if_rsp_valid = hold_if_valid_q | inflight_if_q;
    bus.if_rsp_rdata = if_rsp_data_c;
    bus.dm_rsp_valid = hold_dm_valid_q | inflight_dm_q;
    bus.dm_rsp_rdata = dm_rsp_data_c;
  end

  // Next state: in-flight tracking, hold capture/drain and data-streak counting.
  always_comb begin
    inflight_if_d   = grant_if_c;
    inflight_dm_d   = grant_dm_c;
    inflight_wr_d   = grant_dm_c && (|bus.dm_req_we);
    hold_if_valid_d = hold_if_valid_q;
    hold_if_data_d  = hold_if_data_q;
    hold_dm_valid_d = hold_dm_valid_q;
    hold_dm_data_d  = hold_dm_data_q;
    streak_d        = streak_q;

    if (inflight_if_q && !bus.if_rsp_ready) begin
      hold_if_valid_d = 1'b1;
      hold_if_data_d  = if_rsp_data_c;
    end else if (hold_if_valid_q && bus.if_rsp_ready) begin
      hold_if_valid_d = 1'b0;
      hold_if_data_d  = '0;
    end

    if (inflight_dm_q && !bus.dm_rsp_ready) begin
      hold_dm_valid_d = 1'b1;
      hold_dm_data_d  = dm_rsp_data_c;
    end else if (hold_dm_valid_q && bus.dm_rsp_ready) begin
      hold_dm_valid_d = 1'b0;
      hold_dm_data_d  = '0;
    end

    if (grant_if_c || !bus.if_req_valid) begin
      streak_d = '0;
    end else if (grant_dm_c && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // State registers; reset discards any in-flight or held response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_if_q   <= 1'b0;
      inflight_dm_q   <= 1'b0;
      inflight_wr_q   <= 1'b0;
      hold_if_valid_q <= 1'b0;
      hold_if_data_q  <= '0;
      hold_dm_valid_q <= 1'b0;
      hold_dm_data_q  <= '0;
      streak_q        <= '0;
    end else begin
      inflight_if_q   <= inflight_if_d;
      inflight_dm_q   <= inflight_dm_d;
      inflight_wr_q   <= inflight_wr_d;
      hold_if_valid_q <= hold_if_valid_d;
      hold_if_data_q  <= hold_if_data_d;
      hold_dm_valid_q <= hold_dm_valid_d;
      hold_dm_data_q  <= hold_dm_data_d;
      streak_q        <= streak_d;
    end
  end
endmodule

// File: tb/tb_gs_mem_arbiter.sv
// tb_gs_mem_arbiter: directed stimulus with a transaction-level reference model and SRAM model.
module tb_gs_mem_arbiter;
  localparam int unsigned MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gs_mem_arbiter_if bus ();

  gs_mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM macro model: read data appears the cycle after issue, driven only while oe is high.
  logic [31:0] sram_mem [0:16383];
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (&bus.sram_web) rd_q <= sram_mem[bus.sram_a];
      else for (int b = 0; b < 4; b++)
        if (!bus.sram_web[b]) sram_mem[bus.sram_a][8*b +: 8] <= bus.sram_di[8*b +: 8];
    end
  end
  assign bus.sram_do = bus.sram_oe ? rd_q : 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word memory plus per-port queues of owed responses.
  typedef struct packed { logic [31:0] data; int gcyc; } rsp_t;
  rsp_t        q_if[$];
  rsp_t        q_dm[$];
  rsp_t        ent;
  logic [31:0] ref_mem [0:16383];
  int          streak = 0;
  int          cyc    = 0;
  bit          prev_read = 1'b0;
  bit          e_if, e_dm, g_if, g_dm;
  logic [13:0] a_exp;
  logic [3:0]  web_exp;
  logic [31:0] di_exp;

  // Per-cycle check of every output against the model, then advance the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_if_req_ready", 32'(bus.if_req_ready), 32'h0);
      chk("rst_dm_req_ready", 32'(bus.dm_req_ready), 32'h0);
      chk("rst_if_rsp_valid", 32'(bus.if_rsp_valid), 32'h0);
      chk("rst_dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'h0);
      chk("rst_rdata", bus.if_rsp_rdata | bus.dm_rsp_rdata, 32'h0);
      chk("rst_sram_cs_oe", 32'({bus.sram_cs, bus.sram_oe}), 32'h0);
      chk("rst_sram_web", 32'(bus.sram_web), 32'hF);
      chk("rst_sram_a_di", 32'(bus.sram_a) | bus.sram_di, 32'h0);
      q_if.delete();
      q_dm.delete();
      streak    = 0;
      prev_read = 1'b0;
    end else begin
      // A port may take a new request if it owes nothing, or its owed response is being
      // presented for the first time and consumed right now.
      e_if = (q_if.size() == 0);
      if (q_if.size() == 1) e_if = (cyc - q_if[0].gcyc == 1) && bus.if_rsp_ready;
      e_dm = (q_dm.size() == 0);
      if (q_dm.size() == 1) e_dm = (cyc - q_dm[0].gcyc == 1) && bus.dm_rsp_ready;
      g_if = bus.if_req_valid && e_if && (!(bus.dm_req_valid && e_dm) || streak == MAXS);
      g_dm = !g_if && bus.dm_req_valid && e_dm;

      chk("if_req_ready", 32'(bus.if_req_ready), 32'(g_if));
      chk("dm_req_ready", 32'(bus.dm_req_ready), 32'(g_dm));
      chk("sram_cs", 32'(bus.sram_cs), 32'(g_if | g_dm));
      chk("sram_oe", 32'(bus.sram_oe), 32'(prev_read));

      a_exp = 14'h0; web_exp = 4'hF; di_exp = 32'h0;
      if (g_dm) begin
        a_exp = bus.dm_req_addr[15:2]; web_exp = ~bus.dm_req_we; di_exp = bus.dm_req_wdata;
      end else if (g_if) begin
        a_exp = bus.if_req_addr[15:2];
      end
      chk("sram_a", 32'(bus.sram_a), 32'(a_exp));
      chk("sram_web", 32'(bus.sram_web), 32'(web_exp));
      chk("sram_di", bus.sram_di, di_exp);

      chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(q_if.size() != 0));
      chk("if_rsp_rdata", bus.if_rsp_rdata, (q_if.size() != 0) ? q_if[0].data : 32'h0);
      chk("dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'(q_dm.size() != 0));
      chk("dm_rsp_rdata", bus.dm_rsp_rdata, (q_dm.size() != 0) ? q_dm[0].data : 32'h0);

      if (q_if.size() != 0 && bus.if_rsp_ready) void'(q_if.pop_front());
      if (q_dm.size() != 0 && bus.dm_rsp_ready) void'(q_dm.pop_front());
      if (g_if) begin
        ent.data = ref_mem[a_exp]; ent.gcyc = cyc; q_if.push_back(ent);
      end
      if (g_dm) begin
        ent.gcyc = cyc;
        if (bus.dm_req_we == 4'h0) ent.data = ref_mem[a_exp];
        else begin
          ent.data = 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.dm_req_we[b]) ref_mem[a_exp][8*b +: 8] = bus.dm_req_wdata[8*b +: 8];
        end
        q_dm.push_back(ent);
      end
      prev_read = g_if || (g_dm && bus.dm_req_we == 4'h0);
      if (g_if || !bus.if_req_valid) streak = 0;
      else if (g_dm && streak < MAXS) streak++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid = 1'b0; bus.if_req_addr  = 32'h0;
    bus.dm_req_valid = 1'b0; bus.dm_req_we    = 4'h0;
    bus.dm_req_addr  = 32'h0; bus.dm_req_wdata = 32'h0;
    bus.if_rsp_ready = 1'b1; bus.dm_rsp_ready = 1'b1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [9:0] pat;
  int         wait_cnt, max_wait;

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < 16384; i++) begin
      sram_mem[i] = 32'h5A5A_0000 ^ 32'(i);
      ref_mem[i]  = 32'h5A5A_0000 ^ 32'(i);
    end
    sram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    sram_mem[2]  = 32'hAABBCCDD; ref_mem[2]  = 32'hAABBCCDD;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch from 0x40
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h40;
    @(negedge clk);
    chk("t1_if_ready", 32'(bus.if_req_ready), 32'h1);
    chk("t1_sram_a", 32'(bus.sram_a), 32'h010);
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_if_rsp_valid", 32'(bus.if_rsp_valid), 32'h1);
    chk("t1_if_rsp_rdata", bus.if_rsp_rdata, 32'hDEADBEEF);

    // Partial write then read back
    tick();
    bus.dm_req_valid = 1'b1; bus.dm_req_we = 4'b0011;
    bus.dm_req_addr = 32'h8; bus.dm_req_wdata = 32'h11223344;
    @(negedge clk);
    chk("t3_wr_ready", 32'(bus.dm_req_ready), 32'h1);
    chk("t3_sram_web", 32'(bus.sram_web), 32'hC);
    tick();
    bus.dm_req_we = 4'h0; bus.dm_req_wdata = 32'h0;
    @(negedge clk);
    chk("t3_ack_valid", 32'(bus.dm_rsp_valid), 32'h1);
    chk("t3_ack_rdata", bus.dm_rsp_rdata, 32'h0);
    chk("t3_rd_ready", 32'(bus.dm_req_ready), 32'h1);
    tick();
    bus.dm_req_valid = 1'b0;
    @(negedge clk);
    chk("t3_rd_rdata", bus.dm_rsp_rdata, 32'hAABB3344);
    tick();

    // Both ports request continuously: data streak bounded by MAXS
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h40;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h8;
    pat = 10'h0; wait_cnt = 0; max_wait = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 10) pat = {pat[8:0], bus.dm_req_ready};
      if (bus.if_req_ready) wait_cnt = 0;
      else begin
        wait_cnt++;
        if (wait_cnt > max_wait) max_wait = wait_cnt;
      end
      tick();
    end
    chk("t2_grant_pattern", 32'(pat), 32'(10'b1111011110));
    chk("t2_if_max_wait_le4", 32'(max_wait <= 4), 32'h1);
    idle();
    tick();

    // Data response stalled 3 cycles while fetch keeps flowing
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h40;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
    @(negedge clk);
    chk("t4_dm_grant", 32'(bus.dm_req_ready), 32'h1);
    tick();
    bus.dm_rsp_ready = 1'b0; bus.dm_req_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_held_valid", 32'(bus.dm_rsp_valid), 32'h1);
      chk("t4_held_rdata", bus.dm_rsp_rdata, 32'hDEADBEEF);
      chk("t4_dm_blocked", 32'(bus.dm_req_ready), 32'h0);
      chk("t4_if_granted", 32'(bus.if_req_ready), 32'h1);
      tick();
    end
    bus.dm_rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_drain_valid", 32'(bus.dm_rsp_valid), 32'h1);
    chk("t4_drain_rdata", bus.dm_rsp_rdata, 32'hDEADBEEF);
    chk("t4_drain_blocks", 32'(bus.dm_req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("t4_dm_resumes", 32'(bus.dm_req_ready), 32'h1);
    tick();
    idle();
    tick();

    // Reset with a held data response and an in-flight fetch
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 32'h40;
    tick();
    bus.dm_req_valid = 1'b0; bus.dm_rsp_ready = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    chk("t5_pre_dm_valid", 32'(bus.dm_rsp_valid), 32'h1);
    chk("t5_pre_if_valid", 32'(bus.if_rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_if_valid_0", 32'(bus.if_rsp_valid), 32'h0);
    chk("t5_dm_valid_0", 32'(bus.dm_rsp_valid), 32'h0);
    chk("t5_sram_web_F", 32'(bus.sram_web), 32'hF);
    chk("t5_sram_oe_0", 32'(bus.sram_oe), 32'h0);
    tick();
    rst = 1'b0;
    bus.if_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_stale_if", 32'(bus.if_rsp_valid), 32'h0);
      chk("t5_no_stale_dm", 32'(bus.dm_rsp_valid), 32'h0);
      tick();
    end
    idle();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h40;
    @(negedge clk);
    chk("t5_post_grant", 32'(bus.if_req_ready), 32'h1);
    tick();
    idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
